// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use shift-add and divides use restoring shift-subtract, one bit
// per cycle on operand magnitudes, with the sign fixed up on the final edge.
// Divide-by-zero and signed overflow resolve in the accept cycle.
// Optional macro FAST_MUL_EN: all multiplies finish in the accept cycle on a
// single 2*DATA_W multiplier; the divide path is unaffected.
module muldiv_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        Funct3,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic              stall,
   output logic [DATA_W-1:0] Result
);

   localparam int CW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*DATA_W-1:0] acc_q, acc_d;    // mul: {hi, multiplier}; div: {rem, quotient}
   logic [DATA_W-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;    // final result needs negation

   // operand decode in the accept cycle: signedness, magnitudes, special cases
   logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
   logic [DATA_W-1:0] a_mag, b_mag, special_res;
   always_comb begin
      a_sgn    = (Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
      b_sgn    = (Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
      a_neg    = a_sgn & SrcA[DATA_W-1];
      b_neg    = b_sgn & SrcB[DATA_W-1];
      a_mag    = a_neg ? -SrcA : SrcA;
      b_mag    = b_neg ? -SrcB : SrcB;
      div_zero = Funct3[2] & (SrcB == '0);
      div_ovf  = Funct3[2] & ~Funct3[0] & (SrcA == {1'b1, {(DATA_W-1){1'b0}}}) & (SrcB == '1);
      if (div_zero)
         special_res = Funct3[1] ? SrcA : '1;
      else
         special_res = Funct3[1] ? '0 : SrcA;
   end

`ifdef FAST_MUL_EN
   // single-cycle multiply on sign/zero-extended operands, product mod 2^(2W)
   logic [2*DATA_W-1:0] fa, fb, fprod;
   logic [DATA_W-1:0]   fast_res;
   always_comb begin
      fa       = {{DATA_W{a_neg}}, SrcA};
      fb       = {{DATA_W{b_neg}}, SrcB};
      fprod    = fa * fb;
      fast_res = (Funct3[1:0] == 2'b00) ? fprod[DATA_W-1:0] : fprod[2*DATA_W-1:DATA_W];
   end
`endif

   // one iteration step and the sign-corrected result of the final step
   logic [DATA_W:0]     sum, trial, diff;
   logic [2*DATA_W-1:0] mul_nxt, div_nxt, step_nxt, prod;
   logic [DATA_W-1:0]   quo, rem, mul_res, div_res, fin_res;
   always_comb begin
      sum      = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
      mul_nxt  = acc_q[0] ? {sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};
      trial    = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      diff     = trial - {1'b0, opnd_q};
      div_nxt  = diff[DATA_W] ? {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                              : {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      step_nxt = op_q[2] ? div_nxt : mul_nxt;
      prod     = neg_q ? -step_nxt : step_nxt;
      mul_res  = (op_q[1:0] == 2'b00) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
      quo      = step_nxt[DATA_W-1:0];
      rem      = step_nxt[2*DATA_W-1:DATA_W];
      if (op_q[1])
         div_res = neg_q ? -rem : rem;
      else
         div_res = neg_q ? -quo : quo;
      fin_res  = op_q[2] ? div_res : mul_res;
   end

   // next-state and datapath control
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      neg_d    = neg_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d = Funct3;
               if (div_zero | div_ovf) begin
                  result_d = special_res;
                  state_d  = DONE;
               end
`ifdef FAST_MUL_EN
               else if (!Funct3[2]) begin
                  result_d = fast_res;
                  state_d  = DONE;
               end
`endif
               else begin
                  state_d = RUN;
                  cnt_d   = CW'(DATA_W - 1);
                  neg_d   = (Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
                  if (Funct3[2]) begin
                     acc_d  = {{DATA_W{1'b0}}, a_mag};
                     opnd_d = b_mag;
                  end else begin
                     acc_d  = {{DATA_W{1'b0}}, b_mag};
                     opnd_d = a_mag;
                  end
               end
            end
         end
         RUN: begin
            acc_d = step_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               result_d = fin_res;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a redirect kills whatever is in flight, including a completing op
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign Result = result_q;
   assign stall  = start & ~done_q & ~flush;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with hand-computed expectations.
module tb_muldiv_sequencer;

   logic        clk, reset, start, flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA, SrcB, Result;
   logic        busy, done, stall;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif

   muldiv_sequencer #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
      .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
      .busy(busy), .done(done), .stall(stall), .Result(Result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // issue one op (called 1 time unit after a rising edge) and check it to completion
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int   cyc;
      logic got, stall_ok, busy_seen;
      Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
      #1;
      chk({tag, " stall_at_T"}, 32'(stall), 32'd1);
      cyc = 0; got = 1'b0; stall_ok = 1'b1; busy_seen = 1'b0;
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (busy) busy_seen = 1'b1;
         if (done) got = 1'b1;
         else if (!stall) stall_ok = 1'b0;
      end
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " result"}, Result, exp);
      chk({tag, " stall_until_done"}, 32'(stall_ok), 32'd1);
      chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
      chk({tag, " busy_seen"}, 32'(busy_seen), (lat > 1) ? 32'd1 : 32'd0);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic dn_any;
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      Funct3 = 3'b000; SrcA = '0; SrcB = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset result", Result, 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // signed divide/remainder, iterative
      run_op("div",  3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
      run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
      // divide by zero, one cycle
      run_op("divu0", 3'b101, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
      run_op("remu0", 3'b111, 32'h5, 32'h0, 32'h0000_0005, 1);
      run_op("div0",  3'b100, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 1);
      // signed overflow, one cycle
      run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      // multiplies
      run_op("mul",    3'b000, 32'd7, 32'd6, 32'h0000_002A, ML);
      run_op("mulneg", 3'b000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, ML);
      run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, ML);
      // unsigned divide
      run_op("divu", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 33);
      run_op("remu", 3'b111, 32'd100, 32'd7, 32'h0000_0002, 33);

      // flush on the 10th RUN cycle: no completion, Result keeps 2 from remu
      Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      chk("flush busy_run1", 32'(busy), 32'd1);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      #1;
      chk("flush stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush done", 32'(done), 32'd0);
      chk("flush result", Result, 32'h0000_0002);
      flush = 1'b0; start = 1'b0;
      dn_any = 1'b0;
      repeat (30) begin @(posedge clk); #1; if (done | busy) dn_any = 1'b1; end
      chk("flush no_done", 32'(dn_any), 32'd0);
      chk("flush result_hold", Result, 32'h0000_0002);
      run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'h0000_000E, 33);

      // reset mid-RUN with start held through reset
      Funct3 = 3'b100; SrcA = 32'hFFFF_FF9C; SrcB = 32'd7; start = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      chk("rst busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst result", Result, 32'd0);
      @(posedge clk); #1;
      chk("rst held busy", 32'(busy), 32'd0);
      reset = 1'b0;
      run_op("div_after_reset", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
